tcm_arbiter: RTL

Two-master request arbiter sitting directly upstream of the TCM wrapper. It merges the LSU data port (master 0) and the instruction-fetch port (master 1) onto the single TCM single-port interface. It tracks the TCM's one-cycle read latency and routes each response back to its owner. A one-entry response buffer per master absorbs response back-pressure, so TCM data is never lost.

---
 rtl/tcm_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tcm_arbiter.sv
// Two-master TCM arbiter: m0 = LSU, m1 = instruction fetch, with a one-entry response buffer per master.
// Define TCM_ARB_RR_EN for round-robin arbitration; fixed priority (m0 first) otherwise.
module tcm_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 15
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   // master 0 (LSU)
   input  logic                    m0_req_i,
   output logic                    m0_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic                    m0_we_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic                    m0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,
   input  logic                    m0_rready_i,
   // master 1 (instruction fetch)
   input  logic                    m1_req_i,
   output logic                    m1_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic                    m1_we_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic                    m1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,
   input  logic                    m1_rready_i,
   // TCM single-port interface
   output logic                    tcm_en_o,
   output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
   output logic                    tcm_we_o,
   output logic [DATA_WIDTH/8-1:0] tcm_be_o,
   output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
   input  logic [DATA_WIDTH-1:0]   tcm_rdata_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [1:0]            req;
   logic [1:0]            rready;
   logic [1:0]            elig;
   logic [1:0]            gnt;
   logic [1:0]            rvalid;
   logic [DATA_WIDTH-1:0] rdata [2];
   logic [DATA_WIDTH-1:0] resp_val [2];

   logic [1:0]            pend_q, pend_d;
   logic [1:0]            pend_we_q, pend_we_d;
   logic [1:0]            buf_vld_q, buf_vld_d;
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic [DATA_WIDTH-1:0] buf_d [2];

   logic [1:0]            mst_we;

   assign req    = {m1_req_i, m0_req_i};
   assign rready = {m1_rready_i, m0_rready_i};
   assign mst_we = {m1_we_i, m0_we_i};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_mst
         assign elig[gi] = req[gi] & ~buf_vld_q[gi] & (~pend_q[gi] | rready[gi]);

         // Value of the response currently returning from the TCM (writes return 0).
         assign resp_val[gi] = pend_we_q[gi] ? '0 : tcm_rdata_i;

         assign rvalid[gi] = pend_q[gi] | buf_vld_q[gi];
         assign rdata[gi]  = !rvalid[gi]   ? '0 :
                             buf_vld_q[gi] ? buf_q[gi] : resp_val[gi];

         assign pend_d[gi]    = gnt[gi];
         assign pend_we_d[gi] = gnt[gi] ? mst_we[gi] : pend_we_q[gi];

         always_comb begin
            buf_vld_d[gi] = buf_vld_q[gi];
            buf_d[gi]     = buf_q[gi];
            if (buf_vld_q[gi]) begin
               if (rready[gi]) begin
                  buf_vld_d[gi] = 1'b0;
               end
            end else if (pend_q[gi] && !rready[gi]) begin
               buf_vld_d[gi] = 1'b1;
               buf_d[gi]     = resp_val[gi];
            end
         end
      end
   endgenerate

`ifdef TCM_ARB_RR_EN
   logic rr_q, rr_d;

   always_comb begin
      gnt  = '0;
      rr_d = rr_q;
      if (!rst_i) begin
         if (elig[0] && elig[1]) begin
            gnt[rr_q] = 1'b1;
            rr_d      = ~rr_q;
         end else begin
            gnt = elig;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   always_comb begin
      gnt = '0;
      if (!rst_i) begin
         gnt[0] = elig[0];
         gnt[1] = elig[1] & ~elig[0];
      end
   end
`endif

   // Master 0 fields are presented to the TCM whenever master 1 is not the winner.
   always_comb begin
      tcm_en_o    = 1'b0;
      tcm_addr_o  = '0;
      tcm_we_o    = 1'b0;
      tcm_be_o    = '0;
      tcm_wdata_o = '0;
      if (!rst_i) begin
         tcm_en_o = |gnt;
         if (gnt[1]) begin
            tcm_addr_o  = m1_addr_i;
            tcm_we_o    = m1_we_i;
            tcm_be_o    = m1_be_i;
            tcm_wdata_o = m1_wdata_i;
         end else begin
            tcm_addr_o  = m0_addr_i;
            tcm_we_o    = m0_we_i;
            tcm_be_o    = m0_be_i;
            tcm_wdata_o = m0_wdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q    <= '0;
         pend_we_q <= '0;
         buf_vld_q <= '0;
         for (int i = 0; i < 2; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         pend_q    <= pend_d;
         pend_we_q <= pend_we_d;
         buf_vld_q <= buf_vld_d;
         for (int i = 0; i < 2; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   assign m0_gnt_o    = gnt[0];
   assign m1_gnt_o    = gnt[1];
   assign m0_rvalid_o = rvalid[0];
   assign m1_rvalid_o = rvalid[1];
   assign m0_rdata_o  = rdata[0];
   assign m1_rdata_o  = rdata[1];

   logic unused_be;
   assign unused_be = ^{BE_WIDTH{1'b0}};

endmodule
